data_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port DataMemory between the CPU memory stage and the program/data loader. It serialises requests, drives the memory's read/write strobes, address and write data, and returns read data with a one-cycle acknowledge pulse. Out-of-range addresses are rejected with an error response and never reach the memory. It sits between the pipeline's MEM stage, the loader, and the DataMemory instance.

---
 rtl/data_mem_arbiter_pkg.sv | 21 ++
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter_rr_arbiter_2.sv | 27 ++
 rtl/data_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the DataMemory arbiter: FSM states, requester IDs and the
// address range check used when a command is latched.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_LDR = 1'b1
  } req_id_e;

  // Compared at 64 bits so an address equal to DEPTH never wraps into range.
  function automatic logic addr_out_of_range(input logic [63:0] addr, input logic [63:0] depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the CPU, loader and DataMemory signals around the arbiter.
// slave = arbiter side, master = the surrounding requesters and memory.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_cpu_req;
  logic              in_cpu_we;
  logic [ADDR_W-1:0] in_cpu_addr;
  logic [DATA_W-1:0] in_cpu_wdata;
  logic              out_cpu_ack;
  logic              out_cpu_err;
  logic [DATA_W-1:0] out_cpu_rdata;

  logic              in_ldr_req;
  logic              in_ldr_we;
  logic [ADDR_W-1:0] in_ldr_addr;
  logic [DATA_W-1:0] in_ldr_wdata;
  logic              out_ldr_ack;
  logic              out_ldr_err;
  logic [DATA_W-1:0] out_ldr_rdata;

  logic              out_mem_read;
  logic              out_mem_write;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_wdata;
  logic [DATA_W-1:0] in_mem_rdata;
  logic              out_busy;

  modport slave (
    input  in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata,
    input  in_ldr_req, in_ldr_we, in_ldr_addr, in_ldr_wdata,
    input  in_mem_rdata,
    output out_cpu_ack, out_cpu_err, out_cpu_rdata,
    output out_ldr_ack, out_ldr_err, out_ldr_rdata,
    output out_mem_read, out_mem_write, out_mem_addr, out_mem_wdata,
    output out_busy
  );

  modport master (
    output in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata,
    output in_ldr_req, in_ldr_we, in_ldr_addr, in_ldr_wdata,
    output in_mem_rdata,
    input  out_cpu_ack, out_cpu_err, out_cpu_rdata,
    input  out_ldr_ack, out_ldr_err, out_ldr_rdata,
    input  out_mem_read, out_mem_write, out_mem_addr, out_mem_wdata,
    input  out_busy
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick. Bit 0 is the CPU, bit 1 the loader;
// a requester whose ack is currently high is masked because its req is stale.
module rr_arbiter_2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] ack_mask,
  input  req_id_e    last_grant,
  output req_id_e    winner,
  output logic       valid
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req & ~ack_mask;
    valid    = |eligible;
    winner   = ID_CPU;
    case (eligible)
      2'b01:   winner = ID_CPU;
      2'b10:   winner = ID_LDR;
      2'b11:   winner = (last_grant == ID_CPU) ? ID_LDR : ID_CPU;
      default: winner = ID_CPU;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port DataMemory between the CPU MEM stage and the loader:
// IDLE grants and latches a command, ISSUE strobes the memory, WAIT returns the response.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DEPTH  = 65536,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               in_rst_n,
  data_mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  req_id_e           last_q, last_d;
  req_id_e           id_q, id_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d, ldr_ack_q, ldr_ack_d;
  logic              cpu_err_q, cpu_err_d, ldr_err_q, ldr_err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;

  req_id_e           winner;
  logic              grant_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;
  logic [DATA_W-1:0] resp_data;

  rr_arbiter_2 u_rr (
    .req        ({bus.in_ldr_req, bus.in_cpu_req}),
    .ack_mask   ({ldr_ack_q, cpu_ack_q}),
    .last_grant (last_q),
    .winner     (winner),
    .valid      (grant_valid)
  );

  assign sel_we    = (winner == ID_LDR) ? bus.in_ldr_we    : bus.in_cpu_we;
  assign sel_addr  = (winner == ID_LDR) ? bus.in_ldr_addr  : bus.in_cpu_addr;
  assign sel_wdata = (winner == ID_LDR) ? bus.in_ldr_wdata : bus.in_cpu_wdata;
  assign sel_oor   = addr_out_of_range(64'(sel_addr), 64'(DEPTH));
  assign resp_data = (!we_q && !err_q) ? bus.in_mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_err_d   = cpu_err_q;
    ldr_err_d   = ldr_err_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d     = ST_ISSUE;
          last_d      = winner;
          id_d        = winner;
          we_d        = sel_we;
          err_d       = sel_oor;
          mem_read_d  = !sel_we && !sel_oor;
          mem_write_d = sel_we && !sel_oor;
          // A rejected address is kept off the memory bus entirely.
          if (!sel_oor) begin
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (id_q == ID_CPU) begin
          cpu_ack_d   = 1'b1;
          cpu_err_d   = err_q;
          cpu_rdata_d = resp_data;
        end else begin
          ldr_ack_d   = 1'b1;
          ldr_err_d   = err_q;
          ldr_rdata_d = resp_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= ID_LDR;
      id_q        <= ID_CPU;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      ldr_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_err_q   <= cpu_err_d;
      ldr_err_q   <= ldr_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign bus.out_mem_read  = mem_read_q;
  assign bus.out_mem_write = mem_write_q;
  assign bus.out_mem_addr  = mem_addr_q;
  assign bus.out_mem_wdata = mem_wdata_q;
  assign bus.out_cpu_ack   = cpu_ack_q;
  assign bus.out_cpu_err   = cpu_err_q;
  assign bus.out_cpu_rdata = cpu_rdata_q;
  assign bus.out_ldr_ack   = ldr_ack_q;
  assign bus.out_ldr_err   = ldr_err_q;
  assign bus.out_ldr_rdata = ldr_rdata_q;
  assign bus.out_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a behavioural DataMemory plus a
// word-level reference model that predicts each response from the request alone.
module tb_data_mem_arbiter;
  localparam int DEPTH = 65536;

  logic clk = 1'b0;
  logic in_rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .in_rst_n (in_rst_n),
    .bus      (bus)
  );

  // DataMemory stand-in: registered read, write at the strobe edge, no reset.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] mem_rdata_r = 32'h0;
  always @(posedge clk) begin
    if (bus.out_mem_write) mem[bus.out_mem_addr[15:0]] <= bus.out_mem_wdata;
    if (bus.out_mem_read)  mem_rdata_r <= mem[bus.out_mem_addr[15:0]];
  end
  assign bus.in_mem_rdata = mem_rdata_r;

  int checks = 0;
  int failures = 0;

  // Reference contents: untouched words read back as their own address.
  logic [31:0] model_mem [int unsigned];

  function automatic void model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rd, output logic err);
    if (addr >= DEPTH) begin
      rd = 32'h0; err = 1'b1;
    end else if (we) begin
      model_mem[addr] = wdata; rd = 32'h0; err = 1'b0;
    end else begin
      rd = model_mem.exists(addr) ? model_mem[addr] : addr; err = 1'b0;
    end
  endfunction

  task automatic set_req(input logic id, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (id == 1'b0) begin
      bus.in_cpu_req = req; bus.in_cpu_we = we; bus.in_cpu_addr = addr; bus.in_cpu_wdata = wdata;
    end else begin
      bus.in_ldr_req = req; bus.in_ldr_we = we; bus.in_ldr_addr = addr; bus.in_ldr_wdata = wdata;
    end
  endtask

  function automatic logic ack_of(input logic id);
    return id ? bus.out_ldr_ack : bus.out_cpu_ack;
  endfunction
  function automatic logic err_of(input logic id);
    return id ? bus.out_ldr_err : bus.out_cpu_err;
  endfunction
  function automatic logic [31:0] rdata_of(input logic id);
    return id ? bus.out_ldr_rdata : bus.out_cpu_rdata;
  endfunction

  task automatic rand_fields(output logic we, output logic [31:0] addr, output logic [31:0] wdata);
    we    = 1'($urandom_range(0, 1));
    addr  = ($urandom_range(0, 7) == 0) ? 32'(DEPTH) + $urandom_range(0, 3) : $urandom_range(0, 15);
    wdata = $urandom;
  endtask

  task automatic test_reset();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    in_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy actual=%b required=0", bus.out_busy);
    end
    checks++;
    if ({bus.out_mem_read, bus.out_mem_write, bus.out_cpu_ack, bus.out_ldr_ack, bus.out_cpu_err, bus.out_ldr_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags actual=%b required=000000",
               {bus.out_mem_read, bus.out_mem_write, bus.out_cpu_ack, bus.out_ldr_ack, bus.out_cpu_err, bus.out_ldr_err});
    end
    checks++;
    if ({bus.out_mem_addr, bus.out_mem_wdata, bus.out_cpu_rdata, bus.out_ldr_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h cpu_rdata=%h ldr_rdata=%h required all 0",
               bus.out_mem_addr, bus.out_mem_wdata, bus.out_cpu_rdata, bus.out_ldr_rdata);
    end
    $display("reset: busy=%b strobes=%b%b", bus.out_busy, bus.out_mem_read, bus.out_mem_write);
    @(posedge clk); #1;
    in_rst_n = 1'b1;
  endtask

  // One isolated transaction: latency, strobe count/address and response vs. the model.
  task automatic run_single(input string name, input logic id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int edges;
    int rd_n;
    int wr_n;
    bit got;
    logic oor;
    logic [31:0] exp_rd;
    logic exp_err;
    edges = 0; rd_n = 0; wr_n = 0; got = 0;
    oor = (addr >= DEPTH);
    model_apply(we, addr, wdata, exp_rd, exp_err);
    @(posedge clk); #1;
    set_req(id, 1'b1, we, addr, wdata);
    while (!got && edges < 12) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (bus.out_mem_read || bus.out_mem_write) begin
        rd_n += int'(bus.out_mem_read);
        wr_n += int'(bus.out_mem_write);
        checks++;
        if (bus.out_mem_addr !== addr || (bus.out_mem_write && bus.out_mem_wdata !== wdata)) begin
          failures++;
          $display("FAIL %s_strobe_bus addr=%h wdata=%h required addr=%h wdata=%h",
                   name, bus.out_mem_addr, bus.out_mem_wdata, addr, wdata);
        end
      end
      if (ack_of(id)) got = 1;
    end
    set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s_ack_timeout after %0d edges", name, edges);
    end else begin
      checks++;
      if (edges != 3) begin
        failures++; $display("FAIL %s_latency actual=%0d required=3", name, edges);
      end
      checks++;
      if (rdata_of(id) !== exp_rd || err_of(id) !== exp_err) begin
        failures++;
        $display("FAIL %s_response rdata=%h err=%b required rdata=%h err=%b", name, rdata_of(id), err_of(id), exp_rd, exp_err);
      end
    end
    checks++;
    if (rd_n != int'(!we && !oor) || wr_n != int'(we && !oor)) begin
      failures++;
      $display("FAIL %s_strobe_count read=%0d write=%0d required read=%0d write=%0d",
               name, rd_n, wr_n, int'(!we && !oor), int'(we && !oor));
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (ack_of(id) !== 1'b0 || bus.out_busy !== 1'b0) begin
      failures++; $display("FAIL %s_ack_pulse ack=%b busy=%b required ack=0 busy=0", name, ack_of(id), bus.out_busy);
    end
    $display("%s: id=%0d we=%b addr=%h rdata=%h err=%b latency=%0d", name, id, we, addr, rdata_of(id), err_of(id), edges);
  endtask

  // Continuous random traffic from reset; checks grant order, ack spacing,
  // responses and that the idle requester's response registers hold.
  task automatic run_stream(input string name, input bit use_cpu, input bit use_ldr, input int n_acks);
    logic f_we [2];
    logic [31:0] f_addr [2];
    logic [31:0] f_wdata [2];
    logic [31:0] last_rd [2];
    logic last_err [2];
    int edges;
    int last_edge;
    int acks;
    int exp_gap;
    logic exp_id;
    logic [31:0] exp_rd;
    logic exp_err;
    logic other;
    in_rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rand_fields(f_we[i], f_addr[i], f_wdata[i]);
      last_rd[i] = 32'h0; last_err[i] = 1'b0;
      set_req(1'(i), (i == 0) ? 1'(use_cpu) : 1'(use_ldr), f_we[i], f_addr[i], f_wdata[i]);
    end
    in_rst_n = 1'b1;
    edges = 0; last_edge = 0; acks = 0;
    exp_id = use_cpu ? 1'b0 : 1'b1;
    while (acks < n_acks && edges < 200) begin
      @(posedge clk); edges++;
      @(negedge clk);
      checks++;
      if ((bus.out_mem_read && bus.out_mem_write) || (bus.out_cpu_ack && bus.out_ldr_ack)) begin
        failures++;
        $display("FAIL %s_exclusive rd=%b wr=%b cpu_ack=%b ldr_ack=%b at edge %0d",
                 name, bus.out_mem_read, bus.out_mem_write, bus.out_cpu_ack, bus.out_ldr_ack, edges);
      end
      for (int i = 0; i < 2; i++) begin
        if (ack_of(1'(i))) begin
          other = ~1'(i);
          exp_gap = (acks == 0) ? 3 : ((use_cpu && use_ldr) ? 3 : 4);
          model_apply(f_we[i], f_addr[i], f_wdata[i], exp_rd, exp_err);
          checks++;
          if (1'(i) !== exp_id) begin
            failures++; $display("FAIL %s_grant_order actual=%0d required=%0d", name, i, exp_id);
          end
          checks++;
          if (edges - last_edge != exp_gap) begin
            failures++; $display("FAIL %s_ack_gap actual=%0d required=%0d", name, edges - last_edge, exp_gap);
          end
          checks++;
          if (rdata_of(1'(i)) !== exp_rd || err_of(1'(i)) !== exp_err) begin
            failures++;
            $display("FAIL %s_response id=%0d rdata=%h err=%b required rdata=%h err=%b",
                     name, i, rdata_of(1'(i)), err_of(1'(i)), exp_rd, exp_err);
          end
          checks++;
          if (rdata_of(other) !== last_rd[other] || err_of(other) !== last_err[other]) begin
            failures++;
            $display("FAIL %s_other_hold rdata=%h err=%b required rdata=%h err=%b",
                     name, rdata_of(other), err_of(other), last_rd[other], last_err[other]);
          end
          $display("%s: ack id=%0d we=%b addr=%h rdata=%h err=%b edge=%0d",
                   name, i, f_we[i], f_addr[i], rdata_of(1'(i)), err_of(1'(i)), edges);
          last_rd[i] = exp_rd; last_err[i] = exp_err;
          last_edge = edges;
          acks++;
          exp_id = (use_cpu && use_ldr) ? other : 1'(i);
          if (acks < n_acks) begin
            rand_fields(f_we[i], f_addr[i], f_wdata[i]);
            set_req(1'(i), 1'b1, f_we[i], f_addr[i], f_wdata[i]);
          end else begin
            set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
          end
        end
      end
    end
    checks++;
    if (acks < n_acks) begin
      failures++; $display("FAIL %s_timeout acks=%0d required=%0d", name, acks, n_acks);
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_busy !== 1'b0) begin
      failures++; $display("FAIL %s_drain busy=%b required=0", name, bus.out_busy);
    end
  endtask

  task automatic test_reset_issue();
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 1'b1, 32'h30, 32'h5);
    @(posedge clk); #1;
    checks++;
    if (bus.out_mem_write !== 1'b1 || bus.out_busy !== 1'b1) begin
      failures++; $display("FAIL rst_issue_write write=%b busy=%b required 1 1", bus.out_mem_write, bus.out_busy);
    end
    in_rst_n = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    in_rst_n = 1'b1;
    model_mem[32'h30] = 32'h5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_busy, bus.out_mem_read, bus.out_mem_write, bus.out_cpu_ack, bus.out_ldr_ack, bus.out_cpu_err, bus.out_ldr_err} !== 7'b0 ||
          {bus.out_mem_addr, bus.out_mem_wdata, bus.out_cpu_rdata, bus.out_ldr_rdata} !== 128'h0) begin
        failures++;
        $display("FAIL rst_issue_state busy=%b rd=%b wr=%b acks=%b%b errs=%b%b addr=%h wdata=%h rdata=%h/%h required all 0",
                 bus.out_busy, bus.out_mem_read, bus.out_mem_write, bus.out_cpu_ack, bus.out_ldr_ack,
                 bus.out_cpu_err, bus.out_ldr_err, bus.out_mem_addr, bus.out_mem_wdata, bus.out_cpu_rdata, bus.out_ldr_rdata);
      end
    end
    $display("rst_issue: reset applied during ISSUE, busy=%b", bus.out_busy);
    run_single("rst_issue_read", 1'b0, 1'b0, 32'h30, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = i;
    test_reset();
    run_single("cpu_read", 1'b0, 1'b0, 32'h10, 32'h0);
    run_single("ldr_write", 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    run_single("cpu_read_back", 1'b0, 1'b0, 32'h20, 32'h0);
    run_single("range_depth", 1'b0, 1'b0, 32'd65536, 32'h0);
    run_single("range_last", 1'b0, 1'b0, 32'd65535, 32'h0);
    run_single("range_ldr_write", 1'b1, 1'b1, 32'd70000, 32'h1234);
    run_stream("contention", 1'b1, 1'b1, 12);
    run_stream("back_to_back", 1'b1, 1'b0, 6);
    run_stream("ldr_only", 1'b0, 1'b1, 4);
    test_reset_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
